// File: rtl/snake_defs.sv
// Shared definitions for the snake game: state encodings and default divider constants.
package snake_defs;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int DEF_SLOW_DIV = 25000000;
    localparam int DEF_FAST_DIV = 6000000;
    localparam int DEF_SEC_DIV  = 50000000;
    localparam int DEF_CW       = 26;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear, ripple carry and 9999 -> 0000 wrap.
module bcd_counter4 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic        carry;

    always_comb begin
        value_d = value_q;
        carry   = 1'b1;
        if (clr) begin
            value_d = 16'h0000;
        end else if (inc) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    // >= keeps any out-of-range digit from sticking above 9
                    if (value_q[4*i +: 4] >= 4'd9) begin
                        value_d[4*i +: 4] = 4'd0;
                    end else begin
                        value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q <= 16'h0000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/snake_tick_scheduler.sv
// Game state sequencer generating the move tick, the seconds tick and the BCD elapsed time.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | game active, dividers and elapsed time counting
// ST_PAUSE | frozen, resumes from held values on pause_toggle
// ST_OVER  | frozen with final time displayed, start begins a new game
module snake_tick_scheduler
    import snake_defs::*;
#(
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV,
    parameter int SEC_DIV  = DEF_SEC_DIV,
    parameter int CW       = DEF_CW
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        pause_toggle,
    input  logic        game_over,
    input  logic        speed_fast,
    output logic        move_tick,
    output logic        sec_tick,
    output logic [15:0] bcd_time,
    output logic [1:0]  state,
    output logic        running
);

    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] SEC_LAST  = CW'(SEC_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic          move_tick_q, move_tick_d;
    logic          sec_tick_q, sec_tick_d;
    logic          running_q, running_d;
    logic [CW-1:0] move_last;
    logic          new_game;
    logic          counting;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (game_over)         state_d = ST_OVER;
                else if (pause_toggle) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (game_over)         state_d = ST_OVER;
                else if (pause_toggle) state_d = ST_RUN;
            end
            ST_OVER:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counting only while staying in RUN, so a tick due on the exit edge is dropped
    // and the divider waits at its terminal value until the game resumes.
    assign new_game  = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && (state_d == ST_RUN);
    assign counting  = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign move_last = speed_fast ? FAST_LAST : SLOW_LAST;

    always_comb begin
        mcnt_d      = mcnt_q;
        scnt_d      = scnt_q;
        move_tick_d = 1'b0;
        sec_tick_d  = 1'b0;
        if (new_game) begin
            mcnt_d = '0;
            scnt_d = '0;
        end else if (counting) begin
            if (mcnt_q >= move_last) begin
                mcnt_d      = '0;
                move_tick_d = 1'b1;
            end else begin
                mcnt_d = mcnt_q + CNT_ONE;
            end
            if (scnt_q >= SEC_LAST) begin
                scnt_d     = '0;
                sec_tick_d = 1'b1;
            end else begin
                scnt_d = scnt_q + CNT_ONE;
            end
        end
    end

    assign running_d = (state_d == ST_RUN);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mcnt_q      <= '0;
            scnt_q      <= '0;
            move_tick_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            scnt_q      <= scnt_d;
            move_tick_q <= move_tick_d;
            sec_tick_q  <= sec_tick_d;
            running_q   <= running_d;
        end
    end

    bcd_counter4 u_bcd (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .clr    (new_game),
        .inc    (sec_tick_d),
        .value  (bcd_time)
    );

    assign move_tick = move_tick_q;
    assign sec_tick  = sec_tick_q;
    assign state     = state_q;
    assign running   = running_q;

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Directed bench for snake_tick_scheduler with small dividers, plus a standalone BCD counter.
module tb_snake_tick_scheduler;

    logic        CLOCK_50;
    logic        resetn;
    logic        start;
    logic        pause_toggle;
    logic        game_over;
    logic        speed_fast;
    logic        move_tick;
    logic        sec_tick;
    logic [15:0] bcd_time;
    logic [1:0]  state;
    logic        running;

    logic        b_clr;
    logic        b_inc;
    logic [15:0] b_value;

    int checks;
    int errors;

    snake_tick_scheduler #(
        .SLOW_DIV (10),
        .FAST_DIV (4),
        .SEC_DIV  (8),
        .CW       (8)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .start        (start),
        .pause_toggle (pause_toggle),
        .game_over    (game_over),
        .speed_fast   (speed_fast),
        .move_tick    (move_tick),
        .sec_tick     (sec_tick),
        .bcd_time     (bcd_time),
        .state        (state),
        .running      (running)
    );

    bcd_counter4 u_bcd (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .clr    (b_clr),
        .inc    (b_inc),
        .value  (b_value)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic apply_reset();
        start        = 1'b0;
        pause_toggle = 1'b0;
        game_over    = 1'b0;
        speed_fast   = 1'b0;
        b_clr        = 1'b0;
        b_inc        = 1'b0;
        resetn       = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_toggle = 1'b1;
        tick();
        pause_toggle = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (state !== 2'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d running=%0b, expected 0/0", state, running);
        end
        checks++;
        if (move_tick !== 1'b0 || sec_tick !== 1'b0 || bcd_time !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: move=%0b sec=%0b bcd=%h, expected 0/0/0000",
                     move_tick, sec_tick, bcd_time);
        end
        // inputs other than start are ignored in IDLE
        pause_toggle = 1'b1;
        game_over    = 1'b1;
        tick();
        pause_toggle = 1'b0;
        game_over    = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL idle_ignore: state=%0d, expected 0", state);
        end
    endtask

    task automatic test_basic_run();
        logic exp_m, exp_s;
        apply_reset();
        pulse_start();
        checks++;
        if (state !== 2'd1 || running !== 1'b1) begin
            errors++;
            $display("FAIL start_state: state=%0d running=%0b, expected 1/1", state, running);
        end
        for (int n = 1; n <= 30; n++) begin
            tick();
            exp_m = (n % 10 == 0);
            exp_s = (n % 8 == 0);
            checks++;
            if (move_tick !== exp_m || sec_tick !== exp_s) begin
                errors++;
                $display("FAIL basic_ticks cycle %0d: move=%0b sec=%0b, expected %0b/%0b",
                         n, move_tick, sec_tick, exp_m, exp_s);
            end
            if (n == 16) begin
                checks++;
                if (bcd_time !== 16'h0002) begin
                    errors++;
                    $display("FAIL basic_bcd: bcd=%h, expected 0002", bcd_time);
                end
            end
        end
        // start is ignored while running
        pulse_start();
        checks++;
        if (state !== 2'd1 || bcd_time !== 16'h0003) begin
            errors++;
            $display("FAIL run_ignore_start: state=%0d bcd=%h, expected 1/0003", state, bcd_time);
        end
    endtask

    task automatic test_speed_switch();
        logic exp_m;
        apply_reset();
        pulse_start();
        for (int n = 1; n <= 7; n++) tick();
        speed_fast = 1'b1;
        tick();
        checks++;
        if (move_tick !== 1'b1) begin
            errors++;
            $display("FAIL speed_switch_fire: move=%0b, expected 1", move_tick);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_m = (k % 4 == 0);
            checks++;
            if (move_tick !== exp_m) begin
                errors++;
                $display("FAIL fast_period k=%0d: move=%0b, expected %0b", k, move_tick, exp_m);
            end
        end
        speed_fast = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_m = (k == 10);
            checks++;
            if (move_tick !== exp_m) begin
                errors++;
                $display("FAIL slow_again k=%0d: move=%0b, expected %0b", k, move_tick, exp_m);
            end
        end
    endtask

    task automatic test_pause();
        logic exp_m, exp_s;
        apply_reset();
        pulse_start();
        for (int n = 1; n <= 12; n++) tick();
        pulse_pause();
        checks++;
        if (state !== 2'd2 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_state: state=%0d running=%0b, expected 2/0", state, running);
        end
        for (int k = 1; k <= 50; k++) begin
            tick();
            checks++;
            if (move_tick !== 1'b0 || sec_tick !== 1'b0 || bcd_time !== 16'h0001 || state !== 2'd2) begin
                errors++;
                $display("FAIL pause_hold k=%0d: move=%0b sec=%0b bcd=%h state=%0d, expected 0/0/0001/2",
                         k, move_tick, sec_tick, bcd_time, state);
            end
        end
        pulse_pause();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL resume_state: state=%0d, expected 1", state);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_s = (k == 4);
            exp_m = (k == 8);
            checks++;
            if (move_tick !== exp_m || sec_tick !== exp_s) begin
                errors++;
                $display("FAIL resume_ticks k=%0d: move=%0b sec=%0b, expected %0b/%0b",
                         k, move_tick, sec_tick, exp_m, exp_s);
            end
        end
        checks++;
        if (bcd_time !== 16'h0002) begin
            errors++;
            $display("FAIL resume_bcd: bcd=%h, expected 0002", bcd_time);
        end
    endtask

    task automatic test_suppress();
        apply_reset();
        pulse_start();
        for (int n = 1; n <= 9; n++) tick();
        pulse_pause();
        checks++;
        if (move_tick !== 1'b0 || state !== 2'd2) begin
            errors++;
            $display("FAIL suppress_exit: move=%0b state=%0d, expected 0/2", move_tick, state);
        end
        tick();
        pulse_pause();
        checks++;
        if (move_tick !== 1'b0) begin
            errors++;
            $display("FAIL suppress_resume_edge: move=%0b, expected 0", move_tick);
        end
        tick();
        checks++;
        if (move_tick !== 1'b1) begin
            errors++;
            $display("FAIL held_tick_fires: move=%0b, expected 1", move_tick);
        end
    endtask

    task automatic test_game_over();
        logic exp_m;
        apply_reset();
        pulse_start();
        for (int n = 1; n <= 10; n++) tick();
        pause_toggle = 1'b1;
        game_over    = 1'b1;
        tick();
        pause_toggle = 1'b0;
        game_over    = 1'b0;
        checks++;
        if (state !== 2'd3 || running !== 1'b0) begin
            errors++;
            $display("FAIL over_priority: state=%0d running=%0b, expected 3/0", state, running);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (move_tick !== 1'b0 || sec_tick !== 1'b0 || bcd_time !== 16'h0001) begin
                errors++;
                $display("FAIL over_hold k=%0d: move=%0b sec=%0b bcd=%h, expected 0/0/0001",
                         k, move_tick, sec_tick, bcd_time);
            end
        end
        pulse_pause();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL over_ignore_pause: state=%0d, expected 3", state);
        end
        pulse_start();
        checks++;
        if (state !== 2'd1 || bcd_time !== 16'h0000) begin
            errors++;
            $display("FAIL restart: state=%0d bcd=%h, expected 1/0000", state, bcd_time);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_m = (k == 10);
            checks++;
            if (move_tick !== exp_m) begin
                errors++;
                $display("FAIL restart_move k=%0d: move=%0b, expected %0b", k, move_tick, exp_m);
            end
        end
    endtask

    task automatic test_bcd_carry();
        int cyc;
        apply_reset();
        pulse_start();
        for (int s = 1; s <= 1000; s++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!sec_tick && cyc < 20);
            checks++;
            if (sec_tick !== 1'b1 || cyc != 8 || bcd_time !== to_bcd(s)) begin
                errors++;
                $display("FAIL bcd_count s=%0d: sec=%0b gap=%0d bcd=%h, expected 1/8/%h",
                         s, sec_tick, cyc, bcd_time, to_bcd(s));
                break;
            end
        end
    endtask

    task automatic test_bcd_wrap();
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        checks++;
        if (b_value !== 16'h0000) begin
            errors++;
            $display("FAIL bcd4_clear: value=%h, expected 0000", b_value);
        end
        b_inc = 1'b1;
        for (int i = 1; i <= 9999; i++) begin
            tick();
            checks++;
            if (b_value !== to_bcd(i)) begin
                errors++;
                $display("FAIL bcd4_count i=%0d: value=%h, expected %h", i, b_value, to_bcd(i));
                break;
            end
        end
        tick();
        checks++;
        if (b_value !== 16'h0000) begin
            errors++;
            $display("FAIL bcd4_wrap: value=%h, expected 0000", b_value);
        end
        for (int i = 0; i < 5; i++) tick();
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        b_inc = 1'b0;
        checks++;
        if (b_value !== 16'h0000) begin
            errors++;
            $display("FAIL bcd4_clr_priority: value=%h, expected 0000", b_value);
        end
    endtask

    task automatic test_async_reset();
        logic exp_m;
        apply_reset();
        pulse_start();
        for (int n = 1; n <= 10; n++) tick();
        checks++;
        if (move_tick !== 1'b1 || bcd_time !== 16'h0001) begin
            errors++;
            $display("FAIL pre_reset: move=%0b bcd=%h, expected 1/0001", move_tick, bcd_time);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || move_tick !== 1'b0 || sec_tick !== 1'b0 ||
            bcd_time !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d move=%0b sec=%0b bcd=%h running=%0b, expected all 0",
                     state, move_tick, sec_tick, bcd_time, running);
        end
        #3;
        resetn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (state !== 2'd0 || move_tick !== 1'b0 || sec_tick !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle k=%0d: state=%0d move=%0b sec=%0b, expected 0/0/0",
                         k, state, move_tick, sec_tick);
            end
        end
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_m = (k == 10);
            checks++;
            if (move_tick !== exp_m) begin
                errors++;
                $display("FAIL post_reset_move k=%0d: move=%0b, expected %0b", k, move_tick, exp_m);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_run();
        test_speed_switch();
        test_pause();
        test_suppress();
        test_game_over();
        test_bcd_carry();
        test_bcd_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_tick_scheduler.md
Name: snake_tick_scheduler

Overview:
Central timing controller for the snake game.
- Sequences the game through idle, running, paused and game-over states.
- Generates the snake move tick at a selectable slow or fast rate.
- Generates a 1 Hz seconds tick that drives a 4-digit BCD elapsed-time count for the HEX displays, which are decoded downstream by the existing hex decoder.
- Replaces the free-running divider/counter pair with a single state-aware block.

Parameters:
SLOW_DIV, 25000000, clock cycles per move tick when speed_fast=0
FAST_DIV, 6000000, clock cycles per move tick when speed_fast=1
SEC_DIV, 50000000, clock cycles per seconds tick
CW, 26, divider counter width; must hold max(SLOW_DIV, FAST_DIV, SEC_DIV)-1

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a new game
pause_toggle  in  1  one-cycle pulse; pause or resume
game_over  in  1  one-cycle pulse from game logic; snake died
speed_fast  in  1  level; selects FAST_DIV for move ticks
move_tick  out  1  one-cycle pulse; advance snake one cell
sec_tick  out  1  one-cycle pulse; one elapsed second
bcd_time  out  16  elapsed seconds as 4 BCD digits; [3:0] is the ones digit
state  out  2  0=IDLE 1=RUN 2=PAUSE 3=OVER
running  out  1  high iff state==RUN

Behaviour:
- Reset (resetn=0, takes effect immediately, not on a clock edge):
  - state=IDLE, move_tick=0, sec_tick=0, bcd_time=16'h0000.
  - Both divider counters cleared to 0.
  - Reset asserted mid-game aborts immediately; no tick is emitted on release.
- All outputs are registered.
- State transitions, evaluated each cycle; the state updates on the next edge:
  - IDLE: start -> RUN; all other inputs ignored.
  - RUN: game_over -> OVER. Otherwise pause_toggle -> PAUSE. start is ignored.
  - PAUSE: game_over -> OVER. Otherwise pause_toggle -> RUN. start is ignored.
  - OVER: start -> RUN. pause_toggle is ignored.
- Simultaneous inputs: game_over has priority over pause_toggle.
- New-game clear: every transition into RUN from IDLE or OVER clears bcd_time and both divider counters in the same edge.
- Resume from PAUSE: no clear; counting continues from the held values.
- Move divider (mcnt):
  - Increments only in RUN.
  - When mcnt >= P-1, where P = speed_fast ? FAST_DIV : SLOW_DIV, the next edge sets mcnt=0 and move_tick=1 for exactly one cycle.
  - Using >= means a slow-to-fast switch while mcnt exceeds FAST_DIV-1 fires on the next cycle and never overruns.
  - The first move_tick after entering RUN from IDLE/OVER comes P cycles after the transition edge.
- Seconds divider (scnt): same rule with period SEC_DIV. The edge that sets sec_tick=1 also increments bcd_time.
- Frozen states:
  - PAUSE: both counters and bcd_time hold; move_tick=sec_tick=0.
  - OVER: counters and bcd_time hold, so the final time stays displayed; ticks are 0.
- The tick that would fire on the same edge as a transition out of RUN is suppressed.
- BCD increment:
  - Proper ripple carry: a digit at 9 goes to 0 and carries into the next digit in the same edge.
  - Examples: 0009->0010, 0099->0100, 0999->1000.
  - 9999 wraps to 0000.
  - No digit ever holds a value above 9.
- No combinational path from any input to any output.

Decomposition:
- Shared header snake_defs: state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER, and the default divider constants. The game FSM and VGA logic use the same definitions.
- One sub-module, bcd_counter4:
  - Inputs: clk, resetn, clr, inc.
  - Output: 16-bit BCD value, with ripple carry and wrap.
  - Verified standalone, then instantiated once here.

Test Plan:
All runs use SLOW_DIV=10, FAST_DIV=4, SEC_DIV=8, CW=8.
1. Reset then start at cycle 0 -> state=1 next edge; move_tick pulses at cycles 10, 20, 30 after the transition edge; sec_tick at 8, 16; bcd_time reads 0002 at cycle 16.
2. RUN, speed_fast 0->1 when mcnt=7 -> move_tick on the next cycle, then every 4 cycles; switching back to 0 resumes a 10-cycle period.
3. RUN for 12 cycles, pause_toggle, wait 50, pause_toggle -> no ticks and bcd_time/counters held for 50 cycles; next sec_tick 4 cycles after resume.
4. pause_toggle and game_over in the same cycle during RUN -> state=3, ticks stop; then start -> state=1, bcd_time=0000.
5. Force bcd_time to 0999 and then 9999 (or run 9999 seconds) -> the next sec_tick gives 1000 and 0000 respectively; no digit ever exceeds 9.
6. Drop resetn mid-RUN between clock edges -> outputs clear immediately without waiting for an edge; start is required again to tick.
